// File: rtl/control_unit.sv
//==============================================================================
// Module      : control_unit
// Description : Moore sequencer for a three-bus RISC datapath. It runs a fetch
//               in T0..T2 and a per-opcode execute in T3..T7, and stops in HALT.
//               Optional build macro: CTRL_MUL_DIV_EN adds the mul/div sequences.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module control_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        CON_output,
    input  logic        stop,
    output logic        PCout,
    output logic        MDRout,
    output logic        ZLowout,
    output logic        ZHighout,
    output logic        Cout,
    output logic        MAR_enable,
    output logic        MDR_enable,
    output logic        IR_enable,
    output logic        Y_enable,
    output logic        PC_enable,
    output logic        Z_low_enable,
    output logic        Z_high_enable,
    output logic        HI_enable,
    output logic        LO_enable,
    output logic        GRA,
    output logic        GRB,
    output logic        GRC,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        CON_in,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  operation,
    output logic        run
);

    localparam logic [4:0] c_OP_LD   = 5'b00000;
    localparam logic [4:0] c_OP_ST   = 5'b00010;
    localparam logic [4:0] c_OP_ADD  = 5'b00011;
    localparam logic [4:0] c_OP_AND  = 5'b00101;
    localparam logic [4:0] c_OP_OR   = 5'b00110;
    localparam logic [4:0] c_OP_ALU0 = 5'b00011;
    localparam logic [4:0] c_OP_ALU1 = 5'b01011;
    localparam logic [4:0] c_OP_ADDI = 5'b01100;
    localparam logic [4:0] c_OP_ANDI = 5'b01101;
    localparam logic [4:0] c_OP_ORI  = 5'b01110;
    localparam logic [4:0] c_OP_MUL  = 5'b01111;
    localparam logic [4:0] c_OP_DIV  = 5'b10000;
    localparam logic [4:0] c_OP_BR   = 5'b10010;
    localparam logic [4:0] c_OP_HALT = 5'b11010;

    typedef enum logic [3:0] {
        T0   = 4'd0,
        T1   = 4'd1,
        T2   = 4'd2,
        T3   = 4'd3,
        T4   = 4'd4,
        T5   = 4'd5,
        T6   = 4'd6,
        T7   = 4'd7,
        HALT = 4'd8
    } state_t;

    state_t     r_state;
    state_t     w_next;
    state_t     w_finish;
    logic [4:0] w_opc;
    logic [4:0] w_imm_op;
    logic       w_is_alu;
    logic       w_is_imm;
    logic       w_is_ld;
    logic       w_is_st;
    logic       w_is_br;
    logic       w_is_halt;
    logic       w_is_muldiv;
    logic       w_is_nop;
    logic       w_unused_ir;

    assign w_opc       = ir[31:27];
    assign w_unused_ir = ^ir[26:0];

    assign w_is_alu  = (w_opc >= c_OP_ALU0) && (w_opc <= c_OP_ALU1);
    assign w_is_imm  = (w_opc >= c_OP_ADDI) && (w_opc <= c_OP_ORI);
    assign w_is_ld   = (w_opc == c_OP_LD);
    assign w_is_st   = (w_opc == c_OP_ST);
    assign w_is_br   = (w_opc == c_OP_BR);
    assign w_is_halt = (w_opc == c_OP_HALT);

`ifdef CTRL_MUL_DIV_EN
    assign w_is_muldiv = (w_opc == c_OP_MUL) || (w_opc == c_OP_DIV);
`else
    assign w_is_muldiv = 1'b0;
`endif

    // nop and every undefined opcode share the same empty T3
    assign w_is_nop = !(w_is_alu || w_is_imm || w_is_ld || w_is_st ||
                        w_is_br || w_is_halt || w_is_muldiv);

    assign w_imm_op = (w_opc == c_OP_ADDI) ? c_OP_ADD :
                      (w_opc == c_OP_ANDI) ? c_OP_AND : c_OP_OR;

    // A pending stop is honoured only at the last state of an instruction
    assign w_finish = stop ? HALT : T0;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= T0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = T0;
        case (r_state)
            T0:      w_next = T1;
            T1:      w_next = T2;
            T2:      w_next = T3;
            T3:      w_next = w_is_halt ? HALT : (w_is_nop ? w_finish : T4);
            T4:      w_next = T5;
            T5:      w_next = (w_is_alu || w_is_imm) ? w_finish : T6;
            T6:      w_next = (w_is_br || w_is_muldiv) ? w_finish : T7;
            T7:      w_next = w_finish;
            HALT:    w_next = HALT;
            default: w_next = T0;
        endcase
    end

    always_comb begin
        PCout         = 1'b0;
        MDRout        = 1'b0;
        ZLowout       = 1'b0;
        ZHighout      = 1'b0;
        Cout          = 1'b0;
        MAR_enable    = 1'b0;
        MDR_enable    = 1'b0;
        IR_enable     = 1'b0;
        Y_enable      = 1'b0;
        PC_enable     = 1'b0;
        Z_low_enable  = 1'b0;
        Z_high_enable = 1'b0;
        HI_enable     = 1'b0;
        LO_enable     = 1'b0;
        GRA           = 1'b0;
        GRB           = 1'b0;
        GRC           = 1'b0;
        Rin           = 1'b0;
        Rout          = 1'b0;
        BAout         = 1'b0;
        CON_in        = 1'b0;
        IncPC         = 1'b0;
        Read          = 1'b0;
        Write         = 1'b0;
        operation     = 5'b00000;
        run           = 1'b1;
        // Outputs stay quiet for as long as clear is held, not just until the next edge
        if (clear) begin
            case (r_state)
                T0: begin
                    PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1;
                end
                T1: begin
                    Read = 1'b1; MDR_enable = 1'b1;
                end
                T2: begin
                    MDRout = 1'b1; IR_enable = 1'b1;
                end
                T3: begin
                    if (w_is_alu || w_is_imm) begin
                        GRB = 1'b1; Rout = 1'b1; Y_enable = 1'b1;
                    end else if (w_is_ld || w_is_st) begin
                        GRB = 1'b1; BAout = 1'b1; Y_enable = 1'b1;
                    end else if (w_is_br) begin
                        GRA = 1'b1; Rout = 1'b1; CON_in = 1'b1;
                    end else if (w_is_muldiv) begin
                        GRA = 1'b1; Rout = 1'b1; Y_enable = 1'b1;
                    end
                end
                T4: begin
                    if (w_is_alu) begin
                        GRC = 1'b1; Rout = 1'b1; Z_low_enable = 1'b1; operation = w_opc;
                    end else if (w_is_imm) begin
                        Cout = 1'b1; Z_low_enable = 1'b1; operation = w_imm_op;
                    end else if (w_is_ld || w_is_st) begin
                        Cout = 1'b1; Z_low_enable = 1'b1; operation = c_OP_ADD;
                    end else if (w_is_br) begin
                        PCout = 1'b1; Y_enable = 1'b1;
                    end else if (w_is_muldiv) begin
                        GRB = 1'b1; Rout = 1'b1; Z_low_enable = 1'b1;
                        Z_high_enable = 1'b1; operation = w_opc;
                    end
                end
                T5: begin
                    if (w_is_alu || w_is_imm) begin
                        ZLowout = 1'b1; GRA = 1'b1; Rin = 1'b1;
                    end else if (w_is_ld || w_is_st) begin
                        ZLowout = 1'b1; MAR_enable = 1'b1;
                    end else if (w_is_br) begin
                        Cout = 1'b1; Z_low_enable = 1'b1; operation = c_OP_ADD;
                    end else if (w_is_muldiv) begin
                        ZLowout = 1'b1; LO_enable = 1'b1;
                    end
                end
                T6: begin
                    if (w_is_ld) begin
                        Read = 1'b1; MDR_enable = 1'b1;
                    end else if (w_is_st) begin
                        GRA = 1'b1; Rout = 1'b1; MDR_enable = 1'b1;
                    end else if (w_is_br) begin
                        ZLowout   = CON_output;
                        PC_enable = CON_output;
                    end else if (w_is_muldiv) begin
                        ZHighout = 1'b1; HI_enable = 1'b1;
                    end
                end
                T7: begin
                    if (w_is_ld) begin
                        MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1;
                    end else if (w_is_st) begin
                        Write = 1'b1;
                    end
                end
                HALT:    run = 1'b0;
                default: run = 1'b1;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have clock, input, 1 bit: sole clock, rising edge.
REQ-002 SHALL have clear, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have ir, input, 32 bits: IR contents, with the opcode in ir[31:27].
REQ-004 SHALL have CON_output, input, 1 bit: branch-condition flag from the CON FF.
REQ-005 SHALL have stop, input, 1 bit: halt request.
REQ-006 SHALL have bus-drive selects PCout, MDRout, ZLowout, ZHighout, Cout, each output, 1 bit.
REQ-007 SHALL have register enables MAR_enable, MDR_enable, IR_enable, Y_enable, PC_enable, Z_low_enable, Z_high_enable, HI_enable, LO_enable, each output, 1 bit.
REQ-008 SHALL have GRA, GRB, GRC, Rin, Rout, BAout, CON_in, IncPC, Read, Write, each output, 1 bit.
REQ-009 SHALL have operation, output, 5 bits: ALU opcode.
REQ-010 SHALL have run, output, 1 bit: high unless halted.

Function
REQ-011 SHALL be a Moore FSM with states T0..T7 and HALT; outputs decode from state and ir only, and any output not listed for a state is 0.
REQ-012 SHALL fetch in T0 (PCout, MAR_enable, IncPC), T1 (Read, MDR_enable) and T2 (MDRout, IR_enable); each state lasts 1 cycle.
REQ-013 SHALL treat opcodes 00011..01011 as reg-reg ALU ops: T3 GRB+Rout+Y_enable; T4 GRC+Rout+Z_low_enable with operation=opcode; T5 ZLowout+GRA+Rin; then T0.
REQ-014 SHALL treat 01100 addi, 01101 andi and 01110 ori as immediate ops: same as REQ-013 except T4 uses Cout, with operation 00011, 00101 and 00110 respectively.
REQ-015 SHALL execute ld (00000) as: T3 GRB+BAout+Y_enable; T4 Cout+operation=00011+Z_low_enable; T5 ZLowout+MAR_enable; T6 Read+MDR_enable; T7 MDRout+GRA+Rin.
REQ-016 SHALL execute st (00010) with T3..T5 as ld, then T6 GRA+Rout+MDR_enable with Read=0, then T7 Write.
REQ-017 SHALL execute branch (10010) as: T3 GRA+Rout+CON_in; T4 PCout+Y_enable; T5 Cout+operation=00011+Z_low_enable; T6 ZLowout+PC_enable only if CON_output=1 that cycle, otherwise no enables.
REQ-018 SHALL enter HALT from T3 on halt (11010).
REQ-019 SHALL return to T0 from T3 on nop (11001) and on every undefined opcode, with no side effects.
REQ-020 SHALL complete the current instruction when stop is asserted, and enter HALT instead of T0 if stop=1 in the instruction's final state.
REQ-021 SHALL, in HALT, hold run=0 and all outputs 0; only clear exits HALT.
REQ-022 SHALL, when stop=1 during fetch T0..T2, still complete the fetch and the instruction.

Reset
REQ-023 SHALL, while clear=0, force state=T0, run=1 and all other outputs 0, independent of clock.
REQ-024 SHALL, on the first rising edge after clear deasserts, be in T0 with T0 outputs active; clear asserted mid-instruction aborts it immediately.

Configuration
REQ-025 SHALL, with CTRL_MUL_DIV_EN defined, decode mul (01111) and div (10000) as: T3 GRA+Rout+Y_enable; T4 GRB+Rout+Z_low_enable+Z_high_enable with operation=opcode; T5 ZLowout+LO_enable; T6 ZHighout+HI_enable; then T0.
REQ-026 SHALL, without CTRL_MUL_DIV_EN, treat 01111 and 10000 as nop per REQ-019, with HI_enable, LO_enable and Z_high_enable tied to 0.

Verification
REQ-027 SHALL cover reset: clear=0 mid-T4 -> all outputs 0 and run=1 immediately; after release T0 shows PCout=MAR_enable=IncPC=1.
REQ-028 SHALL cover add: ir=0x18000000-class with opcode 00011 -> T3..T5 strobes per REQ-013, operation=00011 in T4, back to T0 after 6 cycles total.
REQ-029 SHALL cover ld and st: opcodes 00000 and 00010 -> 8-cycle sequences, Read=1 in T6 (ld), Write=1 only in T7 (st).
REQ-030 SHALL cover branch: opcode 10010 with CON_output=1 -> PC_enable=1 in T6; with CON_output=0 -> PC_enable=0.
REQ-031 SHALL cover halt and stop: opcode 11010 -> run=0 from the cycle after T3 and persists; stop=1 during an add -> add completes, then HALT.
REQ-032 SHALL cover the macro both ways: opcode 01111 -> HI_enable=1 in T6 with CTRL_MUL_DIV_EN defined; T0 after T3 with it undefined.
